// File: rtl/uart_cmd_pkg.sv
// Shared constants, helpers and receive-FSM state encoding for the UART command loader.
package uart_cmd_pkg;

    localparam logic [3:0] HDR_SYNC = 4'hA;

    localparam int unsigned DATA_W_DFLT     = 16;
    localparam int unsigned SEL_W_DFLT      = 2;
    localparam int unsigned FIFO_DEPTH_DFLT = 4;

    localparam int unsigned NB      = DATA_W_DFLT / 8;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH_DFLT) + 1;
    localparam int unsigned ENTRY_W = SEL_W_DFLT + DATA_W_DFLT;

    typedef enum logic {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } rx_state_e;

    function automatic int unsigned nb_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // One extra pointer bit separates full from empty after wrap.
    function automatic int unsigned ptr_w_of(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags and a registered read port that
// updates only on pop and holds its value otherwise.
module cmd_fifo
    import uart_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned FPTR_W = ptr_w_of(DEPTH);
    localparam int unsigned ADDR_W = FPTR_W - 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [FPTR_W-1:0] wr_ptr, rd_ptr;
    logic [FPTR_W-1:0] wr_ptr_n, rd_ptr_n, used_n;
    logic              do_push, do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_n = wr_ptr + FPTR_W'(do_push);
        rd_ptr_n = rd_ptr + FPTR_W'(do_pop);
        used_n   = wr_ptr_n - rd_ptr_n;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            full   <= (used_n == FPTR_W'(DEPTH));
            empty  <= (used_n == '0);
            if (do_pop) begin
                rd_data <= mem[rd_ptr[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_cmd_loader.sv
// Frames a UART RX byte stream into {sel, word} commands, buffers them and issues
// spaced one-cycle uart_en strobes to the CPU with the payload on uart_sel/uart_data.
module uart_cmd_loader
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SEL_W       = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              rx_err,
    input  logic              cpu_busy,
    output logic              uart_en,
    output logic [SEL_W-1:0]  uart_sel,
    output logic [DATA_W-1:0] uart_data,
    output logic              frame_err,
    output logic              fifo_full,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned NBYTES = nb_of(DATA_W);
    localparam int unsigned ENT_W  = SEL_W + DATA_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    rx_state_e         state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] word_q, word_d, word_shift;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              frame_err_d;
    logic              push_c, pop_c;
    logic [GAP_W-1:0]  gap_q;
    logic              fifo_empty;
    logic [ENT_W-1:0]  fifo_rd;

    // MSB-first assembly: older bytes shift up, the newest lands in the low byte.
    assign word_shift = DATA_W'({word_q, rx_byte});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_HDR;
            sel_q     <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        word_d      = word_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;
        case (state_q)
            S_HDR: begin
                if (rx_valid) begin
                    if (!rx_err && (rx_byte[7:4] == HDR_SYNC)) begin
                        state_d = S_PAY;
                        sel_d   = rx_byte[SEL_W-1:0];
                        word_d  = '0;
                        idx_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_PAY: begin
                if (rx_valid) begin
                    if (rx_err) begin
                        frame_err_d = 1'b1;
                        state_d     = S_HDR;
                    end else begin
                        word_d = word_shift;
                        tmo_d  = '0;
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(NBYTES - 1)) begin
                            push_c  = 1'b1;
                            state_d = S_HDR;
                        end
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_HDR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // Completed frame goes into the FIFO on the same edge its last byte is sampled.
    cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_data ({sel_q, word_shift}),
        .pop       (pop_c),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop_c = !fifo_empty && (gap_q == '0) && !cpu_busy;

    // The FIFO read register is the output register, so sel/data hold until the next pop.
    assign {uart_sel, uart_data} = fifo_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_en  <= 1'b0;
            gap_q    <= '0;
            drop_cnt <= '0;
        end else begin
            uart_en <= pop_c;
            if (pop_c) begin
                gap_q <= GAP_W'(GAP_CYC);
            end else if (gap_q != '0) begin
                gap_q <= gap_q - GAP_W'(1);
            end
            if (push_c && fifo_full && !pop_c && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_loader.sv
// Self-checking bench: directed frame table, multi-cycle corner sequences and a
// randomized byte stream checked against a frame-level reference model.
module tb_uart_cmd_loader;

    localparam int unsigned GAP = 2;
    localparam int unsigned TMO = 1000;

    typedef struct {
        logic [23:0] bytes;
        logic [2:0]  err;
        int          exp_en;
        logic [1:0]  exp_sel;
        logic [15:0] exp_data;
        int          exp_ferr;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [1:0]  sel;
        logic [15:0] data;
    } pulse_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        rx_valid = 1'b0, rx_err = 1'b0, cpu_busy = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        uart_en, frame_err, fifo_full;
    logic [1:0]  uart_sel;
    logic [15:0] uart_data;
    logic [7:0]  drop_cnt;

    logic        w_rx_valid = 1'b0, w_rx_err = 1'b0, w_cpu_busy = 1'b0;
    logic [7:0]  w_rx_byte = 8'h00;
    logic        w_uart_en, w_frame_err, w_fifo_full;
    logic [3:0]  w_uart_sel;
    logic [31:0] w_uart_data;
    logic [7:0]  w_drop_cnt;

    uart_cmd_loader #(.DATA_W(16), .SEL_W(2), .FIFO_DEPTH(4), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_err(rx_err),
        .cpu_busy(cpu_busy), .uart_en(uart_en), .uart_sel(uart_sel), .uart_data(uart_data),
        .frame_err(frame_err), .fifo_full(fifo_full), .drop_cnt(drop_cnt)
    );

    uart_cmd_loader #(.DATA_W(32), .SEL_W(4), .FIFO_DEPTH(4), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut_w (
        .clk(clk), .reset(reset), .rx_valid(w_rx_valid), .rx_byte(w_rx_byte), .rx_err(w_rx_err),
        .cpu_busy(w_cpu_busy), .uart_en(w_uart_en), .uart_sel(w_uart_sel), .uart_data(w_uart_data),
        .frame_err(w_frame_err), .fifo_full(w_fifo_full), .drop_cnt(w_drop_cnt)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    pulse_t obs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every strobe and error pulse of the 16-bit instance.
    always @(negedge clk) begin
        if (uart_en) obs_q.push_back('{cyc, uart_sel, uart_data});
        if (frame_err) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: collect bytes of a frame, emit {sel, word} when complete.
    logic        rand_busy = 1'b0;
    logic        model_on = 1'b0;
    logic [7:0]  m_frame[$];
    logic [17:0] exp_q[$];
    int          m_ferr = 0;

    task automatic model_byte(input logic [7:0] b, input logic e);
        if (m_frame.size() == 0) begin
            if (!e && b[7:4] == 4'hA) m_frame.push_back(b);
            else m_ferr++;
        end else if (e) begin
            m_ferr++;
            m_frame.delete();
        end else begin
            m_frame.push_back(b);
            if (m_frame.size() == 3) begin
                exp_q.push_back({m_frame[0][1:0], m_frame[1] * 16'd256 + 16'(m_frame[2])});
                m_frame.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_valid = 1'b1;
        rx_byte  = b;
        rx_err   = e;
        if (rand_busy) cpu_busy = ($urandom_range(3) == 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        if (model_on) model_byte(b, e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            if (rand_busy) cpu_busy = ($urandom_range(3) == 0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_w(input logic [7:0] b);
        w_rx_valid = 1'b1;
        w_rx_byte  = b;
        @(posedge clk);
        #1;
        w_rx_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fbase, first_k, nerr;
        logic [23:0] tb_bytes;

        vecs[0] = '{24'hA1000A, 3'b000, 1, 2'd1, 16'h000A, 0};
        vecs[1] = '{24'hA20064, 3'b000, 1, 2'd2, 16'h0064, 0};
        vecs[2] = '{24'h51000A, 3'b000, 0, 2'd2, 16'h0064, 3};
        vecs[3] = '{24'hA31234, 3'b000, 1, 2'd3, 16'h1234, 0};
        vecs[4] = '{24'hA15566, 3'b010, 0, 2'd3, 16'h1234, 2};
        vecs[5] = '{24'hA2000A, 3'b001, 0, 2'd3, 16'h1234, 3};
        vecs[6] = '{24'hAC7F80, 3'b000, 1, 2'd0, 16'h7F80, 0};
        vecs[7] = '{24'hAFFF01, 3'b000, 1, 2'd3, 16'hFF01, 0};

        // Reset state
        #23;
        check("rst_uart_en", uart_en, 0);
        check("rst_uart_sel", uart_sel, 0);
        check("rst_uart_data", uart_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_w_outputs", {w_uart_en, w_uart_sel, w_uart_data, w_frame_err, w_fifo_full, w_drop_cnt}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed frame table
        for (int i = 0; i < 8; i++) begin
            base  = obs_q.size();
            fbase = ferr_cnt;
            tb_bytes = vecs[i].bytes;
            for (int j = 0; j < 3; j++) send_byte(tb_bytes[8*(2-j) +: 8], vecs[i].err[j]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_latency_en", i), uart_en, (vecs[i].exp_en == 1));
            idle(4);
            check($sformatf("v%0d_pulses", i), obs_q.size() - base, vecs[i].exp_en);
            check($sformatf("v%0d_frame_err", i), ferr_cnt - fbase, vecs[i].exp_ferr);
            check($sformatf("v%0d_sel", i), uart_sel, vecs[i].exp_sel);
            check($sformatf("v%0d_data", i), uart_data, vecs[i].exp_data);
        end

        // Timeout after a partial frame
        base = obs_q.size();
        send_byte(8'hA1, 1'b0);
        send_byte(8'h00, 1'b0);
        first_k = -1;
        nerr = 0;
        for (int k = 1; k <= 1001; k++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin
                nerr++;
                if (first_k < 0) first_k = k;
            end
        end
        check("tmo_err_cycle", first_k, 1000);
        check("tmo_err_pulses", nerr, 1);
        check("tmo_no_strobe", obs_q.size() - base, 0);
        send_byte(8'hA3, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        idle(4);
        check("tmo_next_pulses", obs_q.size() - base, 1);
        check("tmo_next_value", {uart_sel, uart_data}, {2'd3, 16'hABCD});

        // Overflow while the CPU is busy, then spaced drain
        cpu_busy = 1'b1;
        base = obs_q.size();
        for (int k = 1; k <= 6; k++) begin
            send_byte(8'hA0, 1'b0);
            send_byte(8'h00, 1'b0);
            send_byte(8'(k), 1'b0);
        end
        idle(2);
        check("ovf_fifo_full", fifo_full, 1);
        check("ovf_drop_cnt", drop_cnt, 2);
        check("ovf_no_strobe", obs_q.size() - base, 0);
        cpu_busy = 1'b0;
        idle(20);
        check("ovf_drain_pulses", obs_q.size() - base, 4);
        for (int k = 0; k < 4 && base + k < obs_q.size(); k++) begin
            check($sformatf("ovf_data%0d", k), obs_q[base+k].data, k + 1);
            if (k > 0) check($sformatf("ovf_space%0d", k), obs_q[base+k].cyc - obs_q[base+k-1].cyc, GAP + 1);
        end
        check("ovf_full_clear", fifo_full, 0);

        // Reset in the middle of a frame
        send_byte(8'hA1, 1'b0);
        send_byte(8'h11, 1'b0);
        rx_valid = 1'b1;
        rx_byte  = 8'h22;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("mid_rst_outputs", {uart_en, uart_sel, uart_data, frame_err, fifo_full, drop_cnt}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        base = obs_q.size();
        idle(3);
        check("mid_rst_no_strobe", obs_q.size() - base, 0);
        send_byte(8'hA0, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        idle(4);
        check("mid_rst_pulses", obs_q.size() - base, 1);
        check("mid_rst_value", {uart_sel, uart_data}, {2'd0, 16'hFFFF});
        check("mid_rst_drop_cnt", drop_cnt, 0);

        // Wide configuration
        send_w(8'hAF);
        send_w(8'hDE);
        send_w(8'hAD);
        send_w(8'hBE);
        send_w(8'hEF);
        check("w_latency_idle", w_uart_en, 0);
        @(posedge clk);
        #1;
        check("w_uart_en", w_uart_en, 1);
        check("w_uart_sel", w_uart_sel, 4'hF);
        check("w_uart_data", w_uart_data, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check("w_uart_en_once", w_uart_en, 0);

        // Randomized stream against the reference model
        base  = obs_q.size();
        fbase = ferr_cnt;
        rand_busy = 1'b1;
        model_on  = 1'b1;
        for (int f = 0; f < 60; f++) begin
            logic [7:0] fb [3];
            fb[0] = ($urandom_range(7) == 0) ? 8'($urandom) : {4'hA, 4'($urandom)};
            fb[1] = 8'($urandom);
            fb[2] = 8'($urandom);
            for (int j = 0; j < 3; j++) begin
                send_byte(fb[j], ($urandom_range(15) == 0));
                idle($urandom_range(2));
            end
            idle(4 + $urandom_range(4));
        end
        rand_busy = 1'b0;
        model_on  = 1'b0;
        cpu_busy  = 1'b0;
        idle(TMO + 20);
        if (m_frame.size() != 0) begin
            m_ferr++;
            m_frame.delete();
        end
        check("rand_pulses", obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
            check($sformatf("rand_cmd%0d", i), {obs_q[base+i].sel, obs_q[base+i].data}, exp_q[i]);
        check("rand_frame_err", ferr_cnt - fbase, m_ferr);
        check("rand_drop_cnt", drop_cnt, 0);
        for (int i = 1; i < obs_q.size(); i++)
            check($sformatf("spacing%0d", i), (obs_q[i].cyc - obs_q[i-1].cyc) >= GAP + 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_loader.md
Name: uart_cmd_loader

Overview:
- Converts a UART receiver byte stream into framed CPU load strobes: uart_en, uart_sel and uart_data.
- Sits between the UART RX block and the CPU's uart_en/uart_sel/uart_data inputs.
- Replaces bench-driven strobes with hardware-driven ones.
- Generalised in word width and channel count; adds frame sync, timeout, FIFO buffering, strobe spacing and drop accounting.

Parameters:
- DATA_W, 16: payload word width; multiple of 8, range 8..64.
- SEL_W, 2: channel select width; range 1..4.
- FIFO_DEPTH, 4: buffered frames; power of 2, at least 2.
- GAP_CYC, 2: minimum idle cycles between uart_en pulses; 0 allowed.
- TIMEOUT_CYC, 1000: maximum cycles between bytes of one frame.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- rx_err  in  1  receiver framing/parity error, sampled only with rx_valid.
- cpu_busy  in  1  when high, the CPU cannot accept a strobe; issue is held off.
- uart_en  out  1  one-cycle load strobe to the CPU.
- uart_sel  out  SEL_W  channel select, valid with uart_en and held afterwards.
- uart_data  out  DATA_W  payload word, valid with uart_en and held afterwards.
- frame_err  out  1  one-cycle pulse on a bad header, rx_err or timeout.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- drop_cnt  out  8  count of frames lost to overflow; saturates at 255.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - While reset is low, all state clears asynchronously.
  - Reset values: uart_en=0, uart_sel=0, uart_data=0, frame_err=0, fifo_full=0, drop_cnt=0. FSM is in S_HDR, FIFO is empty, gap counter is 0.
- Frame format:
  - One header byte, then NB=DATA_W/8 payload bytes, most significant byte first.
  - Header: bits [7:4] must be 4'hA; bits [SEL_W-1:0] give sel; all other bits are ignored.
- Receive FSM:
  - S_HDR:
    - rx_valid with a valid header and rx_err=0: latch sel, clear the byte index, go to S_PAY.
    - Invalid header or rx_err: pulse frame_err, stay in S_HDR.
  - S_PAY:
    - Each rx_valid shifts rx_byte into the word and increments the index.
    - On byte NB: write {sel, word} to the FIFO on that same edge, return to S_HDR.
    - rx_err on any payload byte: discard the partial frame, pulse frame_err, return to S_HDR. No write.
    - Timeout counter resets on every accepted byte.
    - If TIMEOUT_CYC cycles pass with no rx_valid: discard, pulse frame_err, return to S_HDR.
- FIFO:
  - Write on a completed frame.
  - If full and no pop in the same cycle: the frame is dropped and drop_cnt increments, saturating at 255.
  - Push and pop in the same cycle while full: both take effect; no drop.
  - Pointer width is log2(FIFO_DEPTH)+1 so full and empty are distinguished on wrap.
- Issue:
  - Pop when FIFO is non-empty, gap counter is 0 and cpu_busy=0.
  - The cycle after the pop edge: uart_en=1 for exactly one cycle, with uart_sel/uart_data loaded from the entry.
  - The gap counter then loads GAP_CYC. Pulses are therefore at least GAP_CYC+1 cycles apart, rising edge to rising edge minus 1.
  - uart_sel/uart_data hold their values until the next pop.
  - cpu_busy is only checked at pop decision; a strobe already issued is never retracted.
- Latency:
  - Last byte sampled at edge E with FIFO empty and gap 0 gives uart_en high between edges E+1 and E+2.
- Reset asserted mid-frame or mid-strobe: everything clears immediately; the partial frame is lost and not counted in drop_cnt.

Decomposition:
- Package uart_cmd_pkg holds:
  - HDR_SYNC = 4'hA.
  - Derived constants: NB, PTR_W, and the entry width SEL_W+DATA_W.
  - FSM state encoding: S_HDR, S_PAY.
- One sub-module: cmd_fifo, a parametrised synchronous FIFO with width and depth parameters, push/pop/full/empty, the same async active-low reset, and a 1-cycle registered read.

Test Plan:
- Frame bytes 0xA1,0x00,0x0A with cpu_busy=0 -> one uart_en pulse with uart_sel=1, uart_data=0x000A, arriving 1 cycle after the last byte's edge. Then frame 0xA2,0x00,0x64 -> uart_sel=2, uart_data=0x0064. Values hold between pulses.
- Header 0x51, then 0x00,0x0A -> frame_err pulses once and the payload bytes are treated as bad headers (2 more pulses). No uart_en. A following valid frame 0xA3,0x12,0x34 -> uart_sel=3, uart_data=0x1234.
- Bytes 0xA1,0x00 then silence for 1001 cycles -> frame_err at cycle 1000 and no uart_en. The next valid frame is delivered normally.
- cpu_busy=1, then 6 back-to-back valid frames (data 1..6) -> fifo_full=1 and drop_cnt=2. Release cpu_busy -> 4 pulses with data 1,2,3,4, spaced exactly GAP_CYC+1=3 cycles apart.
- Assert reset low during the second payload byte, release, send 0xA0,0xFF,0xFF -> no strobe for the aborted frame, then exactly one pulse with uart_sel=0, uart_data=0xFFFF, and drop_cnt=0.
- With DATA_W=32, SEL_W=4: frame 0xAF,0xDE,0xAD,0xBE,0xEF -> uart_sel=0xF, uart_data=0xDEADBEEF.
